// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial front end for a bit-serial adder: accepts an operand pair
// with a length field and emits the pair LSB first, one bit of each per cycle.
module serial_operand_serializer #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned LW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LW-1:0]    in_len,
    input  logic             hold,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (cnt_q == '0);

    // Handshake and serial stream are combinational so a new word can load on
    // the final bit of the previous one without a bubble.
    assign in_rdy = !rst && ((state_q == IDLE) ||
                             ((state_q == SHIFT) && cnt_zero && !hold));
    assign accept = in_vld && in_rdy;
    assign vld    = (state_q == SHIFT) && !hold;
    assign a      = vld && sh_a_q[0];
    assign b      = vld && sh_b_q[0];
    assign last   = vld && cnt_zero;
    assign busy   = (state_q == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sh_a_d  = in_a;
                    sh_b_d  = in_b;
                    cnt_d   = in_len;
                end
            end
            SHIFT: begin
                // hold freezes everything; accept is already blocked by in_rdy
                if (!hold) begin
                    if (!cnt_zero) begin
                        sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                        sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                        cnt_d  = cnt_q - LW'(1);
                    end else if (accept) begin
                        sh_a_d = in_a;
                        sh_b_d = in_b;
                        cnt_d  = in_len;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed self-checking bench for serial_operand_serializer (WIDTH=8).
module tb_serial_operand_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_len;
    logic       hold;
    logic       vld, a, b, last, busy;

    int checks = 0;
    int failures = 0;

    serial_operand_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_a(in_a), .in_b(in_b), .in_len(in_len), .hold(hold),
        .vld(vld), .a(a), .b(b), .last(last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Apply inputs on the falling edge, settle, then the caller samples.
    task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                         input logic [2:0] dl, input logic h);
        @(negedge clk);
        in_vld = v; in_a = da; in_b = db; in_len = dl; hold = h;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_vld = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_len = 3'd7; hold = 1'b0;
        #1;
        checks++;
        if ({in_rdy, vld, a, b, last, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000", {in_rdy, vld, a, b, last, busy});
        end
        repeat (2) @(posedge clk);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_rdy=%b busy=%b want in_rdy=1 busy=0", in_rdy, busy);
        end
    endtask

    // Word A5/3C len 7, optionally with in_vld+garbage during cycles 2..7.
    task automatic test_basic(input bit noise);
        logic [7:0] wa, wb;
        wa = 8'hA5; wb = 8'h3C;
        drive(1'b1, wa, wb, 3'd7, 1'b0);
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_accept in_rdy=%b want=1", in_rdy);
        end
        for (int i = 0; i < 8; i++) begin
            if (noise && i >= 1 && i <= 6)
                drive(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
            else
                drive(1'b0, 8'h5A, 8'hC3, 3'd3, 1'b0);
            checks++;
            if (vld !== 1'b1 || a !== wa[i] || b !== wb[i] ||
                last !== (i == 7) || in_rdy !== (i == 7) || busy !== 1'b1) begin
                failures++;
                $display("FAIL basic_bit%0d noise=%0d got vld=%b a=%b b=%b last=%b rdy=%b busy=%b want 1 %b %b %b %b 1",
                         i, noise, vld, a, b, last, in_rdy, busy, wa[i], wb[i], i == 7, i == 7);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        checks++;
        if (vld !== 1'b0 || busy !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_idle vld=%b busy=%b rdy=%b want 0 0 1", vld, busy, in_rdy);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] ea, eb, el;
        ea = 10'b10_1010_0101; eb = 10'b11_0011_1100; el = 10'b10_1000_0000;
        drive(1'b1, 8'hA5, 8'h3C, 3'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 7) drive(1'b1, 8'h02, 8'h03, 3'd1, 1'b0);
            else        drive(1'b0, 8'hFF, 8'hFF, 3'd7, 1'b0);
            checks++;
            if (vld !== 1'b1 || a !== ea[i] || b !== eb[i] || last !== el[i]) begin
                failures++;
                $display("FAIL b2b_bit%0d got vld=%b a=%b b=%b last=%b want 1 %b %b %b",
                         i, vld, a, b, last, ea[i], eb[i], el[i]);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        checks++;
        if (busy !== 1'b0 || vld !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b vld=%b want 0 0", busy, vld);
        end
    endtask

    // Runs a word under a per-cycle hold pattern and tracks the expected bit index.
    task automatic test_hold(input logic [7:0] wa, input logic [7:0] wb, input logic [2:0] len,
                             input logic [15:0] hpat, input int ncyc);
        int idx;
        logic eh, el;
        idx = 0;
        drive(1'b1, wa, wb, len, 1'b0);
        for (int c = 0; c < ncyc; c++) begin
            eh = hpat[c];
            drive(1'b0, 8'hFF, 8'hFF, 3'd7, eh);
            el = !eh && (idx == int'(len));
            checks++;
            if (vld !== !eh || a !== (!eh && wa[idx]) || b !== (!eh && wb[idx]) ||
                last !== el || in_rdy !== el) begin
                failures++;
                $display("FAIL hold_cyc%0d got vld=%b a=%b b=%b last=%b rdy=%b want %b %b %b %b %b",
                         c, vld, a, b, last, in_rdy, !eh, !eh && wa[idx], !eh && wb[idx], el, el);
            end
            if (!eh) idx++;
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        checks++;
        if (busy !== 1'b0 || idx != int'(len) + 1) begin
            failures++;
            $display("FAIL hold_end busy=%b bits=%0d want busy=0 bits=%0d", busy, idx, int'(len) + 1);
        end
    endtask

    task automatic test_len0;
        // hold in IDLE must not block acceptance
        drive(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL len0_idle_hold_rdy in_rdy=%b want=1", in_rdy);
        end
        drive(1'b0, 8'hFF, 8'hFF, 3'd7, 1'b0);
        checks++;
        if ({vld, a, b, last} !== 4'b1111) begin
            failures++;
            $display("FAIL len0_bit got=%b want=1111", {vld, a, b, last});
        end
        drive(1'b0, 8'hFF, 8'hFF, 3'd7, 1'b0);
        checks++;
        if (vld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len0_idle vld=%b busy=%b want 0 0", vld, busy);
        end
        // upper operand bits beyond in_len stay unseen
        drive(1'b1, 8'hF8, 8'hF8, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
            checks++;
            if (a !== 1'b0 || b !== 1'b0 || vld !== (i < 3) || last !== (i == 2)) begin
                failures++;
                $display("FAIL trunc_cyc%0d got vld=%b a=%b b=%b last=%b want %b 0 0 %b",
                         i, vld, a, b, last, i < 3, i == 2);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 8'hA5, 8'h3C, 3'd7, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        in_vld = 1'b1; in_a = 8'h01; in_b = 8'h01; in_len = 3'd7;
        rst = 1'b1;
        #1;
        checks++;
        if (vld !== 1'b0 || last !== 1'b0 || in_rdy !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs vld=%b last=%b rdy=%b busy=%b want 0 0 0 0", vld, last, in_rdy, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_rdy in_rdy=%b want=1", in_rdy);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
            checks++;
            if (vld !== 1'b1 || a !== (i == 0) || b !== (i == 0) || last !== (i == 7)) begin
                failures++;
                $display("FAIL rstmid_bit%0d got vld=%b a=%b b=%b last=%b want 1 %b %b %b",
                         i, vld, a, b, last, i == 0, i == 0, i == 7);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_back_to_back();
        test_hold(8'hA5, 8'h3C, 3'd7, 16'h000C, 10);
        test_hold(8'h02, 8'h01, 3'd1, 16'h0002, 3);
        test_len0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
